// File: rtl/sram_frame_writer.sv
// Burst writer for an asynchronous SRAM: accepts words over a valid/ready port
// and writes each one with a SETUP / STROBE / HOLD cycle sequence.
module sram_frame_writer #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [19:0] StartAddr,
  input  logic [19:0] Count,
  input  logic [15:0] In_Data,
  input  logic [1:0]  In_ByteEn,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [19:0] SRAM_AddrExport,
  output logic [15:0] SRAM_DataExport,
  output logic        SRAM_DataOE,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned AW = 20;
  localparam int unsigned SW = 2;
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    STROBE,
    HOLD,
    FINISH
  } state_t;

  state_t        state;
  logic [AW-1:0] remaining;
  logic [SW-1:0] strobe_cnt;

  // SRAM_AddrExport doubles as the running word address; the bus is only
  // qualified by CE, so its value outside a write is irrelevant.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state           <= IDLE;
      remaining       <= '0;
      strobe_cnt      <= '0;
      In_Ready        <= 1'b0;
      SRAM_AddrExport <= '0;
      SRAM_DataExport <= '0;
      SRAM_DataOE     <= 1'b0;
      CE              <= 1'b1;
      UB              <= 1'b1;
      LB              <= 1'b1;
      OE              <= 1'b1;
      WE              <= 1'b1;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      OE   <= 1'b1;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (Count != '0) begin
              state           <= WAIT_DATA;
              SRAM_AddrExport <= StartAddr;
              remaining       <= Count;
              Busy            <= 1'b1;
              In_Ready        <= 1'b1;
            end else begin
              state <= FINISH;
              Done  <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (In_Valid && In_Ready) begin
            state           <= SETUP;
            In_Ready        <= 1'b0;
            SRAM_DataExport <= In_Data;
            UB              <= ~In_ByteEn[1];
            LB              <= ~In_ByteEn[0];
            CE              <= 1'b0;
            SRAM_DataOE     <= 1'b1;
          end
        end
        SETUP: begin
          state      <= STROBE;
          WE         <= 1'b0;
          strobe_cnt <= '0;
        end
        STROBE: begin
          if (strobe_cnt == STROBE_LAST) begin
            state      <= HOLD;
            WE         <= 1'b1;
            strobe_cnt <= '0;
          end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
          end
        end
        HOLD: begin
          CE          <= 1'b1;
          UB          <= 1'b1;
          LB          <= 1'b1;
          SRAM_DataOE <= 1'b0;
          remaining   <= remaining - 1'b1;
          if (remaining == AW'(1)) begin
            state <= FINISH;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            state           <= WAIT_DATA;
            SRAM_AddrExport <= SRAM_AddrExport + 1'b1;
            In_Ready        <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_frame_writer.sv
// Bench for sram_frame_writer: two builds (STROBE_CYCLES 1 and 3), table-driven
// and random bursts checked against a word-level model of the expected SRAM writes.
module tb_sram_frame_writer;

  localparam int NI = 2;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
    logic        ub;
    logic        lb;
    logic [7:0]  len;
  } wr_t;

  typedef struct {
    logic [19:0] addr;
    logic [19:0] cnt;
    int          gap;
    bit          poke;
    logic [15:0] dbase;
    logic [1:0]  be0;
    logic [1:0]  be1;
    int          exp_done;
    logic [19:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start [NI];
  logic [19:0] saddr [NI];
  logic [19:0] cnt_in[NI];
  logic [15:0] din   [NI];
  logic [1:0]  bein  [NI];
  logic        vin   [NI];
  logic        rdy   [NI];
  logic [19:0] aexp  [NI];
  logic [15:0] dexp  [NI];
  logic        doe   [NI];
  logic        ce    [NI];
  logic        ub    [NI];
  logic        lb    [NI];
  logic        oe    [NI];
  logic        we    [NI];
  logic        busy  [NI];
  logic        done  [NI];

  int errors = 0;
  int checks = 0;
  wr_t wq[NI][$];
  int done_cnt[NI] = '{default: 0};
  int ce_cnt  [NI] = '{default: 0};
  int cyc     [NI] = '{default: 0};
  int done_at [NI] = '{default: 0};
  int scyc    [NI] = '{1, 3};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_frame_writer #(.STROBE_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .Clk(clk), .Reset_n(rst_n), .Start(start[g]), .StartAddr(saddr[g]),
      .Count(cnt_in[g]), .In_Data(din[g]), .In_ByteEn(bein[g]), .In_Valid(vin[g]),
      .In_Ready(rdy[g]), .SRAM_AddrExport(aexp[g]), .SRAM_DataExport(dexp[g]),
      .SRAM_DataOE(doe[g]), .CE(ce[g]), .UB(ub[g]), .LB(lb[g]), .OE(oe[g]),
      .WE(we[g]), .Busy(busy[g]), .Done(done[g])
    );

    wr_t         cur;
    logic        pwe = 1'b1;
    logic        pce = 1'b1;
    logic [19:0] pa  = '0;
    logic [15:0] pd  = '0;
    logic        pub = 1'b1;
    logic        plb = 1'b1;

    // Bus monitor: protocol rules every cycle, plus a log of each WE-low pulse.
    always @(negedge clk) begin
      cyc[g]++;
      if (rst_n) begin
        checks++;
        if ((!we[g] && (!oe[g] || !doe[g] || ce[g])) ||
            (!ce[g] && !pce && (aexp[g] != pa || dexp[g] != pd || ub[g] != pub || lb[g] != plb))) begin
          errors++;
          $display("FAIL bus_protocol inst%0d: got we=%b oe=%b doe=%b ce=%b addr=%h data=%h, required no WE/OE overlap, WE only when driving, stable bus under CE",
                   g, we[g], oe[g], doe[g], ce[g], aexp[g], dexp[g]);
        end
      end
      if (!ce[g]) ce_cnt[g]++;
      if (done[g]) begin
        done_cnt[g]++;
        done_at[g] = cyc[g];
      end
      if (!we[g] && pwe) begin
        cur.a = aexp[g]; cur.d = dexp[g]; cur.ub = ub[g]; cur.lb = lb[g]; cur.len = 8'd1;
      end else if (!we[g] && !pwe) begin
        cur.len = cur.len + 8'd1;
      end else if (we[g] && !pwe) begin
        wq[g].push_back(cur);
      end
      pwe = we[g]; pce = ce[g]; pa = aexp[g]; pd = dexp[g]; pub = ub[g]; plb = lb[g];
    end
  end

  task automatic nsample();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h required %0h", name, i, got, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    nsample();
    while (!rdy[i] && n < 200) begin
      nsample();
      n++;
    end
    chk("ready_seen", i, 64'(rdy[i]), 64'd1);
  endtask

  task automatic check_idle_outputs(input string name, input int i);
    chk({name, "_we"},   i, 64'(we[i]),   64'd1);
    chk({name, "_ce"},   i, 64'(ce[i]),   64'd1);
    chk({name, "_doe"},  i, 64'(doe[i]),  64'd0);
    chk({name, "_busy"}, i, 64'(busy[i]), 64'd0);
    chk({name, "_done"}, i, 64'(done[i]), 64'd0);
    chk({name, "_rdy"},  i, 64'(rdy[i]),  64'd0);
    chk({name, "_addr"}, i, 64'(aexp[i]), 64'd0);
  endtask

  // One burst: builds the expected write list, drives the source, then compares.
  task automatic run_burst(input int i, input vec_t v, input bit rnd);
    wr_t         exp_q[$];
    wr_t         w;
    int          dc0, cc0, s0, n;
    logic [19:0] a;
    logic [15:0] dw;
    logic [1:0]  bw;
    nsample();
    dc0 = done_cnt[i];
    cc0 = ce_cnt[i];
    wq[i].delete();
    saddr[i] = v.addr;
    cnt_in[i] = v.cnt;
    start[i] = 1'b1;
    s0 = cyc[i];
    @(posedge clk); #1;
    start[i] = 1'b0;
    saddr[i] = 20'($urandom);
    cnt_in[i] = 20'($urandom);
    if (v.poke) start[i] = 1'b1;
    a = v.addr;
    for (int k = 0; k < int'(v.cnt); k++) begin
      dw = rnd ? 16'($urandom) : v.dbase + 16'(k);
      bw = rnd ? 2'($urandom) : ((k % 2 == 0) ? v.be0 : v.be1);
      w.a = a; w.d = dw; w.ub = ~bw[1]; w.lb = ~bw[0]; w.len = 8'(scyc[i]);
      exp_q.push_back(w);
      a = a + 20'd1;
      if (v.gap > 0) begin
        vin[i] = 1'b0;
        wait_ready(i);
        for (int j = 0; j < v.gap; j++) begin
          if (j > 0) nsample();
          chk("ready_during_wait", i, 64'(rdy[i]), 64'd1);
          chk("ce_during_wait",    i, 64'(ce[i]),  64'd1);
          chk("we_during_wait",    i, 64'(we[i]),  64'd1);
          @(posedge clk); #1;
        end
      end
      din[i] = dw;
      bein[i] = bw;
      vin[i] = 1'b1;
      wait_ready(i);
      @(posedge clk); #1;
    end
    vin[i] = 1'b0;
    n = 0;
    nsample();
    while (!done[i] && n < 200) begin
      nsample();
      n++;
    end
    chk("done_seen", i, 64'(done[i]), 64'(v.exp_done));
    chk("busy_at_done", i, 64'(busy[i]), 64'd0);
    if (v.gap == 0)
      chk("burst_latency", i, 64'(done_at[i] - s0), 64'(int'(v.cnt) * (3 + scyc[i]) + 1));
    @(posedge clk); #1;
    start[i] = 1'b0;
    nsample();
    chk("done_one_cycle", i, 64'(done[i]), 64'd0);
    chk("busy_after", i, 64'(busy[i]), 64'd0);
    nsample();
    chk("busy_after2", i, 64'(busy[i]), 64'd0);
    chk("done_pulses", i, 64'(done_cnt[i] - dc0), 64'(v.exp_done));
    chk("ce_low_cycles", i, 64'(ce_cnt[i] - cc0), 64'(int'(v.cnt) * (2 + scyc[i])));
    chk("write_count", i, 64'(wq[i].size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wq[i].size(); k++)
      chk("write_word", i, 64'(wq[i][k]), 64'(exp_q[k]));
    if (v.cnt != '0 && wq[i].size() > 0)
      chk("last_addr", i, 64'(wq[i][wq[i].size() - 1].a), 64'(v.exp_last));
  endtask

  // Reset lands while the second word is strobing; the burst must simply vanish.
  task automatic reset_mid_strobe(input int i);
    int dc0, n;
    nsample();
    dc0 = done_cnt[i];
    wq[i].delete();
    saddr[i] = 20'h00700;
    cnt_in[i] = 20'd3;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    din[i] = 16'h5A5A;
    bein[i] = 2'b11;
    vin[i] = 1'b1;
    n = 0;
    nsample();
    while (!(wq[i].size() == 1 && !we[i]) && n < 200) begin
      nsample();
      n++;
    end
    chk("reached_2nd_strobe", i, 64'(wq[i].size() == 1 && !we[i]), 64'd1);
    rst_n = 1'b0;
    nsample();
    check_idle_outputs("after_reset", i);
    vin[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) nsample();
    chk("no_done_after_reset", i, 64'(done_cnt[i] - dc0), 64'd0);
    chk("no_retry", i, 64'(wq[i].size()), 64'd2);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    tbl[0] = '{20'h00100, 20'd3, 0,  1'b0, 16'hA001, 2'b11, 2'b11, 1, 20'h00102};
    tbl[1] = '{20'h00200, 20'd2, 10, 1'b0, 16'hB001, 2'b11, 2'b11, 1, 20'h00201};
    tbl[2] = '{20'hFFFFF, 20'd2, 0,  1'b0, 16'hC001, 2'b11, 2'b11, 1, 20'h00000};
    tbl[3] = '{20'h00300, 20'd2, 0,  1'b0, 16'hD001, 2'b10, 2'b01, 1, 20'h00301};
    tbl[4] = '{20'h00400, 20'd0, 0,  1'b0, 16'hE001, 2'b11, 2'b11, 1, 20'h00000};
    tbl[5] = '{20'h00500, 20'd2, 1,  1'b1, 16'hF001, 2'b01, 2'b11, 1, 20'h00501};
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; saddr[i] = '0; cnt_in[i] = '0;
      din[i] = '0; bein[i] = '0; vin[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    nsample();
    for (int i = 0; i < NI; i++) begin
      check_idle_outputs("reset", i);
      chk("reset_oe", i, 64'(oe[i]), 64'd1);
      chk("reset_ublb", i, 64'({ub[i], lb[i]}), 64'd3);
      chk("reset_data", i, 64'(dexp[i]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      foreach (tbl[t]) run_burst(i, tbl[t], 1'b0);
      repeat (6) begin
        v.addr = ($urandom_range(0, 3) == 0) ? 20'hFFFFE : 20'($urandom);
        v.cnt = 20'($urandom_range(1, 4));
        v.gap = $urandom_range(0, 3);
        v.poke = 1'($urandom_range(0, 1));
        v.dbase = '0; v.be0 = '0; v.be1 = '0;
        v.exp_done = 1;
        v.exp_last = v.addr + v.cnt - 20'd1;
        run_burst(i, v, 1'b1);
      end
      reset_mid_strobe(i);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
